// File: rtl/rob_retire.sv
// Eight-entry reorder buffer that retires one completed entry per cycle, in allocation order.
// A retired entry produces a one-cycle register-file write strobe, or a store-commit pulse for stores.
module rob_retire #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          alloc_valid,
    input  logic [3:0]    alloc_opcode,
    input  logic [3:0]    alloc_dest,
    output logic          alloc_ready,
    output logic [2:0]    alloc_tag,
    input  logic          wb_valid,
    input  logic [2:0]    wb_tag,
    input  logic [DW-1:0] wb_value,
    input  logic          flush,
    output logic          rf_we,
    output logic [3:0]    rf_waddr,
    output logic [DW-1:0] rf_wdata,
    output logic          store_commit,
    output logic [2:0]    retire_tag,
    output logic [3:0]    count
);

    localparam logic [3:0] OP_STORE = 4'b0100;

    logic [2:0]    head;
    logic [2:0]    tail;
    logic [7:0]    busy;
    logic [7:0]    done;
    logic [3:0]    opc_q  [8];
    logic [3:0]    dest_q [8];
    logic [DW-1:0] val_q  [8];

    logic do_alloc;
    logic do_retire;
    logic do_wb;

    // Full is judged from the registered count only, so a full buffer stays full for the cycle.
    assign alloc_ready = ~count[3];
    assign alloc_tag   = tail;
    assign do_alloc    = alloc_valid & alloc_ready;
    assign do_retire   = busy[head] & done[head];
    assign do_wb       = wb_valid & busy[wb_tag];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            done         <= '0;
            rf_we        <= 1'b0;
            rf_waddr     <= '0;
            rf_wdata     <= '0;
            store_commit <= 1'b0;
            retire_tag   <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            busy         <= '0;
            done         <= '0;
            rf_we        <= 1'b0;
            store_commit <= 1'b0;
        end else begin
            rf_we        <= 1'b0;
            store_commit <= 1'b0;
            if (do_wb)
                done[wb_tag] <= 1'b1;
            // Retire looks at the registered done bit, so a same-cycle writeback waits a cycle.
            if (do_retire) begin
                busy[head] <= 1'b0;
                done[head] <= 1'b0;
                head       <= head + 3'd1;
                retire_tag <= head;
                if (opc_q[head] == OP_STORE) begin
                    store_commit <= 1'b1;
                end else begin
                    rf_we    <= 1'b1;
                    rf_waddr <= dest_q[head];
                    rf_wdata <= val_q[head];
                end
            end
            if (do_alloc) begin
                busy[tail] <= 1'b1;
                done[tail] <= 1'b0;
                tail       <= tail + 3'd1;
            end
            case ({do_alloc, do_retire})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
        end
    end

    // Payload needs no reset: busy/done gate every use of it.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (do_alloc) begin
                opc_q[tail]  <= alloc_opcode;
                dest_q[tail] <= alloc_dest;
            end
            if (do_wb)
                val_q[wb_tag] <= wb_value;
        end
    end

endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: a vector table for the in-order retire, store and flush
// behaviour, plus hand-written sequences for the full/wrap case and asynchronous reset.
module tb_rob_retire;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alloc_valid = 1'b0;
    logic [3:0]    alloc_opcode = '0;
    logic [3:0]    alloc_dest = '0;
    logic          alloc_ready;
    logic [2:0]    alloc_tag;
    logic          wb_valid = 1'b0;
    logic [2:0]    wb_tag = '0;
    logic [DW-1:0] wb_value = '0;
    logic          flush = 1'b0;
    logic          rf_we;
    logic [3:0]    rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          store_commit;
    logic [2:0]    retire_tag;
    logic [3:0]    count;

    int checks = 0;
    int errors = 0;

    rob_retire #(.DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_opcode(alloc_opcode), .alloc_dest(alloc_dest),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .flush(flush),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .store_commit(store_commit), .retire_tag(retire_tag), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       av;  logic [3:0] op;  logic [3:0] dst;
        logic       wv;  logic [2:0] wt;  logic [7:0] wval;
        logic       fl;
        logic       e_we; logic [3:0] e_wa; logic [7:0] e_wd;
        logic       e_st; logic [2:0] e_rt; logic [3:0] e_cnt;
        logic       e_rdy; logic [2:0] e_tag;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic av, logic [3:0] op, logic [3:0] dst,
                                logic wv, logic [2:0] wt, logic [7:0] wval, logic fl,
                                logic e_we, logic [3:0] e_wa, logic [7:0] e_wd, logic e_st,
                                logic [2:0] e_rt, logic [3:0] e_cnt, logic e_rdy, logic [2:0] e_tag);
        vec_t v;
        v.av = av; v.op = op; v.dst = dst; v.wv = wv; v.wt = wt; v.wval = wval; v.fl = fl;
        v.e_we = e_we; v.e_wa = e_wa; v.e_wd = e_wd; v.e_st = e_st; v.e_rt = e_rt;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_tag = e_tag;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic av, input logic [3:0] op, input logic [3:0] dst,
                         input logic wv, input logic [2:0] wt, input logic [7:0] wval,
                         input logic fl);
        alloc_valid = av; alloc_opcode = op; alloc_dest = dst;
        wb_valid = wv; wb_tag = wt; wb_value = wval; flush = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 8'h00, 1'b0);
    endtask

    initial begin
        // av op dst | wv wt wval | fl || we wa wd | st rt cnt rdy tag
        // single add, dest 3
        vecs.push_back(mk(1, 4'h1, 4'd3, 0, 0, 8'h00, 0,  0, 4'd0, 8'h00, 0, 0, 4'd1, 1, 3'd1));
        vecs.push_back(mk(0, 4'h0, 4'd0, 1, 0, 8'h2A, 0,  0, 4'd0, 8'h00, 0, 0, 4'd1, 1, 3'd1));
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 0,  1, 4'd3, 8'h2A, 0, 0, 4'd0, 1, 3'd1));
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 0,  0, 4'd3, 8'h2A, 0, 0, 4'd0, 1, 3'd1));
        // flush back to tag 0, then out-of-order writebacks retire in order
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 1,  0, 4'd3, 8'h2A, 0, 0, 4'd0, 1, 3'd0));
        vecs.push_back(mk(1, 4'h1, 4'd4, 0, 0, 8'h00, 0,  0, 4'd3, 8'h2A, 0, 0, 4'd1, 1, 3'd1));
        vecs.push_back(mk(1, 4'h0, 4'd6, 0, 0, 8'h00, 0,  0, 4'd3, 8'h2A, 0, 0, 4'd2, 1, 3'd2));
        vecs.push_back(mk(0, 4'h0, 4'd0, 1, 1, 8'h11, 0,  0, 4'd3, 8'h2A, 0, 0, 4'd2, 1, 3'd2));
        vecs.push_back(mk(0, 4'h0, 4'd0, 1, 0, 8'h22, 0,  0, 4'd3, 8'h2A, 0, 0, 4'd2, 1, 3'd2));
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 0,  1, 4'd4, 8'h22, 0, 0, 4'd1, 1, 3'd2));
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 0,  1, 4'd6, 8'h11, 0, 1, 4'd0, 1, 3'd2));
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 0,  0, 4'd6, 8'h11, 0, 1, 4'd0, 1, 3'd2));
        // store dest 5 at tag 0: commit pulse, no register write
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 1,  0, 4'd6, 8'h11, 0, 1, 4'd0, 1, 3'd0));
        vecs.push_back(mk(1, 4'h4, 4'd5, 0, 0, 8'h00, 0,  0, 4'd6, 8'h11, 0, 1, 4'd1, 1, 3'd1));
        vecs.push_back(mk(0, 4'h0, 4'd0, 1, 0, 8'h77, 0,  0, 4'd6, 8'h11, 0, 1, 4'd1, 1, 3'd1));
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 0,  0, 4'd6, 8'h11, 1, 0, 4'd0, 1, 3'd1));
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 0,  0, 4'd6, 8'h11, 0, 0, 4'd0, 1, 3'd1));
        // three entries, head done, then flush with alloc and writeback in the same cycle
        vecs.push_back(mk(1, 4'h1, 4'd1, 0, 0, 8'h00, 0,  0, 4'd6, 8'h11, 0, 0, 4'd1, 1, 3'd2));
        vecs.push_back(mk(1, 4'h2, 4'd2, 0, 0, 8'h00, 0,  0, 4'd6, 8'h11, 0, 0, 4'd2, 1, 3'd3));
        vecs.push_back(mk(1, 4'h3, 4'd3, 0, 0, 8'h00, 0,  0, 4'd6, 8'h11, 0, 0, 4'd3, 1, 3'd4));
        vecs.push_back(mk(0, 4'h0, 4'd0, 1, 1, 8'h55, 0,  0, 4'd6, 8'h11, 0, 0, 4'd3, 1, 3'd4));
        vecs.push_back(mk(1, 4'h1, 4'd7, 1, 2, 8'h66, 1,  0, 4'd6, 8'h11, 0, 0, 4'd0, 1, 3'd0));
        vecs.push_back(mk(0, 4'h0, 4'd0, 0, 0, 8'h00, 0,  0, 4'd6, 8'h11, 0, 0, 4'd0, 1, 3'd0));
        // writeback in the retire cycle does not alter the value being retired
        vecs.push_back(mk(1, 4'h1, 4'd9, 0, 0, 8'h00, 0,  0, 4'd6, 8'h11, 0, 0, 4'd1, 1, 3'd1));
        vecs.push_back(mk(0, 4'h0, 4'd0, 1, 0, 8'h01, 0,  0, 4'd6, 8'h11, 0, 0, 4'd1, 1, 3'd1));
        vecs.push_back(mk(0, 4'h0, 4'd0, 1, 0, 8'h02, 0,  1, 4'd9, 8'h01, 0, 0, 4'd0, 1, 3'd1));

        // reset values
        #3;
        chk("rst_count", count, 4'd0);
        chk("rst_ready", alloc_ready, 1'b1);
        chk("rst_tag", alloc_tag, 3'd0);
        chk("rst_we", rf_we, 1'b0);
        chk("rst_store", store_commit, 1'b0);
        chk("rst_rtag", retire_tag, 3'd0);
        #4 rst_n = 1'b1;
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].av, vecs[i].op, vecs[i].dst, vecs[i].wv, vecs[i].wt, vecs[i].wval, vecs[i].fl);
            step();
            chk($sformatf("v%0d_we", i), rf_we, vecs[i].e_we);
            chk($sformatf("v%0d_waddr", i), rf_waddr, vecs[i].e_wa);
            chk($sformatf("v%0d_wdata", i), rf_wdata, vecs[i].e_wd);
            chk($sformatf("v%0d_store", i), store_commit, vecs[i].e_st);
            chk($sformatf("v%0d_rtag", i), retire_tag, vecs[i].e_rt);
            chk($sformatf("v%0d_count", i), count, vecs[i].e_cnt);
            chk($sformatf("v%0d_ready", i), alloc_ready, vecs[i].e_rdy);
            chk($sformatf("v%0d_tag", i), alloc_tag, vecs[i].e_tag);
        end

        // full buffer, ignored ninth alloc, then retire and alloc in one cycle
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 8'h00, 1'b1);
        step();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 4'h1, 4'(k + 8), 1'b0, 3'd0, 8'h00, 1'b0);
            step();
        end
        chk("full_count", count, 4'd8);
        chk("full_ready", alloc_ready, 1'b0);
        chk("full_tag_wrap", alloc_tag, 3'd0);
        drive(1'b1, 4'h1, 4'd1, 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk("ninth_count", count, 4'd8);
        chk("ninth_tag", alloc_tag, 3'd0);
        drive(1'b0, 4'h0, 4'd0, 1'b1, 3'd0, 8'h30, 1'b0);
        step();
        chk("full_wait_count", count, 4'd8);
        drive(1'b0, 4'h0, 4'd0, 1'b1, 3'd1, 8'h31, 1'b0);
        step();
        chk("ret0_count", count, 4'd7);
        chk("ret0_we", rf_we, 1'b1);
        chk("ret0_waddr", rf_waddr, 4'd8);
        chk("ret0_wdata", rf_wdata, 8'h30);
        drive(1'b1, 4'h1, 4'd2, 1'b0, 3'd0, 8'h00, 1'b0);
        step();
        chk("both_count", count, 4'd7);
        chk("both_tag", alloc_tag, 3'd1);
        chk("both_we", rf_we, 1'b1);
        chk("both_rtag", retire_tag, 3'd1);
        chk("both_wdata", rf_wdata, 8'h31);

        // asynchronous reset mid-cycle with entries in flight
        drive(1'b0, 4'd0, 4'd0, 1'b0, 3'd0, 8'h00, 1'b1);
        step();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 4'h1, 4'd4, 1'b0, 3'd0, 8'h00, 1'b0);
            step();
        end
        drive(1'b0, 4'h0, 4'd0, 1'b1, 3'd0, 8'h44, 1'b0);
        step();
        idle();
        step();
        chk("pre_rst_we", rf_we, 1'b1);
        chk("pre_rst_count", count, 4'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_count", count, 4'd0);
        chk("arst_ready", alloc_ready, 1'b1);
        chk("arst_tag", alloc_tag, 3'd0);
        chk("arst_we", rf_we, 1'b0);
        chk("arst_waddr", rf_waddr, 4'd0);
        chk("arst_wdata", rf_wdata, 8'h00);
        chk("arst_rtag", retire_tag, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'h1, 4'd2, 1'b1, 3'd1, 8'h99, 1'b0);
        step();
        chk("post_rst_count", count, 4'd1);
        chk("post_rst_tag", alloc_tag, 3'd1);
        idle();
        step();
        step();
        chk("post_rst_no_retire", rf_we, 1'b0);
        chk("post_rst_hold", count, 4'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
